// File: rtl/tpa_pkg.sv
// Shared types and constants for transpose_partial_accumulator.
// COL_W   : width of the column index carried with each partial sum.
// MAX_DIM : largest column count the fixed-width index can address.
package tpa_pkg;

   localparam int COL_W   = 4;
   localparam int MAX_DIM = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } tpa_state_e;

endpackage

// File: rtl/tpa_sat_add.sv
// Adds a sign-extended DW-bit partial sum into an ACC_W-bit accumulator.
// With TPA_SATURATE_EN defined the result clamps to the signed ACC_W range and
// ovf_o flags the clamp; otherwise the add wraps and ovf_o is always 0.
// Ports:
//   acc_i    in  ACC_W  current accumulator value (signed)
//   addend_i in  DW     partial sum (signed)
//   sum_o    out ACC_W  new accumulator value
//   ovf_o    out 1      result was clamped
module tpa_sat_add #(
   parameter int ACC_W = 32,
   parameter int DW    = 16
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic signed [DW-1:0]    addend_i,
   output logic signed [ACC_W-1:0] sum_o,
   output logic                    ovf_o
);

`ifdef TPA_SATURATE_EN
   // One guard bit: a sign mismatch between the top two bits means overflow.
   logic signed [ACC_W:0] wide;

   assign wide = $signed({acc_i[ACC_W-1], acc_i}) + (ACC_W+1)'(addend_i);

   always_comb begin
      ovf_o = wide[ACC_W] ^ wide[ACC_W-1];
      sum_o = wide[ACC_W-1:0];
      if (ovf_o) begin
         sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sum_o = acc_i + ACC_W'(addend_i);
   assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/transpose_partial_accumulator.sv
// Per-column accumulator behind the systolic-array output sync stage.
// Accumulates signed partial sums per column over num_pass passes, then drains
// one column sum per valid/ready handshake.
// Optional build macro: TPA_SATURATE_EN (saturating adds + sticky overflow).
// Ports:
//   clk, rst            clock, async active-high reset
//   start, num_pass     begin a run (IDLE only); passes to accumulate, 0 -> 1
//   partial_valid, col_id, partial_data   incoming partial-sum strobe
//   acc_out_valid/ready/data/col          drain handshake
//   busy, done          run in progress; one-cycle pulse at end of drain
//   err_drop, overflow  sticky flags, cleared by accepted start
//
// state | meaning
// IDLE  | waiting for start; strobes dropped
// ACCUM | adding partials; column Dimension-1 closes a pass
// DRAIN | presenting acc[drain_idx] until column Dimension-1 is accepted
module transpose_partial_accumulator
   import tpa_pkg::*;
#(
   parameter int Dimension = 16,
   parameter int DW        = 16,
   parameter int ACC_W     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [7:0]              num_pass,
   input  logic                    partial_valid,
   input  logic [COL_W-1:0]        col_id,
   input  logic signed [DW-1:0]    partial_data,
   output logic                    acc_out_valid,
   input  logic                    acc_out_ready,
   output logic signed [ACC_W-1:0] acc_out_data,
   output logic [COL_W-1:0]        acc_out_col,
   output logic                    busy,
   output logic                    done,
   output logic                    err_drop,
   output logic                    overflow
);

   localparam logic [COL_W:0]   DIM_L    = (COL_W+1)'(Dimension);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(Dimension - 1);

   tpa_state_e              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q [Dimension];
   logic signed [ACC_W-1:0] acc_d [Dimension];
   logic [7:0]              pass_cnt_q, pass_cnt_d;
   logic [7:0]              target_q, target_d;
   logic [COL_W-1:0]        drain_idx_q, drain_idx_d;
   logic                    err_q, err_d;
   logic                    ovf_q, ovf_d;
   logic                    done_q, done_d;

   logic                    col_ok;
   logic signed [ACC_W-1:0] add_in, add_sum, drain_data;
   logic                    add_ovf;

   assign col_ok = {1'b0, col_id} < DIM_L;

   // Index by compare rather than direct subscript so col_id values beyond
   // Dimension never address a nonexistent entry.
   always_comb begin
      add_in     = '0;
      drain_data = '0;
      for (int i = 0; i < Dimension; i++) begin
         if (col_id == COL_W'(i))      add_in     = acc_q[i];
         if (drain_idx_q == COL_W'(i)) drain_data = acc_q[i];
      end
   end

   tpa_sat_add #(.ACC_W(ACC_W), .DW(DW)) u_add (
      .acc_i    (add_in),
      .addend_i (partial_data),
      .sum_o    (add_sum),
      .ovf_o    (add_ovf)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      pass_cnt_d  = pass_cnt_q;
      target_d    = target_q;
      drain_idx_d = drain_idx_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            // start outranks a coincident strobe: flags end up cleared.
            if (start) begin
               state_d     = ACCUM;
               for (int i = 0; i < Dimension; i++) acc_d[i] = '0;
               pass_cnt_d  = '0;
               target_d    = (num_pass == 8'd0) ? 8'd1 : num_pass;
               drain_idx_d = '0;
               err_d       = 1'b0;
               ovf_d       = 1'b0;
            end else if (partial_valid) begin
               err_d = 1'b1;
            end
         end
         ACCUM: begin
            if (partial_valid) begin
               if (col_ok) begin
                  for (int i = 0; i < Dimension; i++) begin
                     if (col_id == COL_W'(i)) acc_d[i] = add_sum;
                  end
                  if (add_ovf) ovf_d = 1'b1;
                  if (col_id == LAST_COL) begin
                     pass_cnt_d = pass_cnt_q + 8'd1;
                     if (pass_cnt_q + 8'd1 == target_q) begin
                        state_d     = DRAIN;
                        drain_idx_d = '0;
                     end
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (partial_valid) err_d = 1'b1;
            if (acc_out_ready) begin
               if (drain_idx_q == LAST_COL) begin
                  state_d     = IDLE;
                  drain_idx_d = '0;
                  done_d      = 1'b1;
               end else begin
                  drain_idx_d = drain_idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < Dimension; i++) acc_q[i] <= '0;
         pass_cnt_q  <= '0;
         target_q    <= '0;
         drain_idx_q <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         pass_cnt_q  <= pass_cnt_d;
         target_q    <= target_d;
         drain_idx_q <= drain_idx_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   end

   assign acc_out_valid = (state_q == DRAIN);
   assign acc_out_data  = acc_out_valid ? drain_data : '0;
   assign acc_out_col   = acc_out_valid ? drain_idx_q : '0;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign err_drop      = err_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_transpose_partial_accumulator.sv
module tb_transpose_partial_accumulator;

   localparam int DIM   = 4;
   localparam int DW    = 16;
   localparam int ACC_W = 20;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    start = 1'b0;
   logic [7:0]              num_pass = '0;
   logic                    partial_valid = 1'b0;
   logic [3:0]              col_id = '0;
   logic signed [DW-1:0]    partial_data = '0;
   logic                    acc_out_valid;
   logic                    acc_out_ready = 1'b0;
   logic signed [ACC_W-1:0] acc_out_data;
   logic [3:0]              acc_out_col;
   logic                    busy, done, err_drop, overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   transpose_partial_accumulator #(.Dimension(DIM), .DW(DW), .ACC_W(ACC_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_pass      (num_pass),
      .partial_valid (partial_valid),
      .col_id        (col_id),
      .partial_data  (partial_data),
      .acc_out_valid (acc_out_valid),
      .acc_out_ready (acc_out_ready),
      .acc_out_data  (acc_out_data),
      .acc_out_col   (acc_out_col),
      .busy          (busy),
      .done          (done),
      .err_drop      (err_drop),
      .overflow      (overflow)
   );

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] np);
      start    = 1'b1;
      num_pass = np;
      tick();
      start    = 1'b0;
   endtask

   task automatic send(input logic [3:0] c, input logic signed [DW-1:0] d);
      partial_valid = 1'b1;
      col_id        = c;
      partial_data  = d;
      tick();
      partial_valid = 1'b0;
   endtask

   // Zero-stall drain of all four columns, then the done pulse.
   task automatic drain_expect(input string tag, input logic signed [31:0] e0,
                               input logic signed [31:0] e1,
                               input logic signed [31:0] e2,
                               input logic signed [31:0] e3);
      logic signed [31:0] e [4];
      e = '{e0, e1, e2, e3};
      acc_out_ready = 1'b1;
      for (int c = 0; c < DIM; c++) begin
         chk({tag, "_valid"}, 32'(acc_out_valid), 1);
         chk({tag, "_col"}, 32'(acc_out_col), c);
         chk({tag, "_data"}, 32'(acc_out_data), e[c]);
         tick();
      end
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_busy_end"}, 32'(busy), 0);
      chk({tag, "_valid_end"}, 32'(acc_out_valid), 0);
      tick();
      chk({tag, "_done_pulse"}, 32'(done), 0);
   endtask

   initial begin
      #12;
      chk("rst_valid", 32'(acc_out_valid), 0);
      chk("rst_data", 32'(acc_out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err_drop), 0);
      chk("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;
      tick();

      // Two passes of 1..4 -> doubled sums.
      do_start(8'd2);
      chk("t1_busy", 32'(busy), 1);
      for (int p = 0; p < 2; p++)
         for (int c = 0; c < DIM; c++) begin
            chk("t1_no_valid_early", 32'(acc_out_valid), 0);
            send(4'(c), 16'(c + 1));
         end
      drain_expect("t1", 2, 4, 6, 8);

      // num_pass = 0 behaves as one pass.
      do_start(8'd0);
      for (int c = 0; c < DIM; c++) send(4'(c), -16'sd5);
      drain_expect("t2", -5, -5, -5, -5);

      // Back-pressure at column 1.
      do_start(8'd1);
      send(4'd2, 16'sd30);
      send(4'd0, 16'sd10);
      send(4'd1, 16'sd20);
      send(4'd3, 16'sd40);
      acc_out_ready = 1'b1;
      chk("t3_col0", 32'(acc_out_data), 10);
      tick();
      acc_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t3_hold_col", 32'(acc_out_col), 1);
         chk("t3_hold_data", 32'(acc_out_data), 20);
         chk("t3_hold_valid", 32'(acc_out_valid), 1);
         tick();
      end
      acc_out_ready = 1'b1;
      chk("t3_col1", 32'(acc_out_data), 20);
      tick();
      chk("t3_col2_idx", 32'(acc_out_col), 2);
      chk("t3_col2", 32'(acc_out_data), 30);
      tick();
      chk("t3_col3", 32'(acc_out_data), 40);
      tick();
      chk("t3_done", 32'(done), 1);
      tick();

      // Dropped strobes and err_drop lifecycle.
      send(4'd0, 16'sd99);
      chk("t4_err_idle", 32'(err_drop), 1);
      do_start(8'd1);
      chk("t4_err_clr", 32'(err_drop), 0);
      send(4'd7, 16'sd100);
      chk("t4_err_col7", 32'(err_drop), 1);
      for (int c = 0; c < DIM; c++) send(4'(c), 16'sd1);
      drain_expect("t4", 1, 1, 1, 1);
      chk("t4_err_sticky", 32'(err_drop), 1);
      partial_valid = 1'b1;
      col_id        = 4'd0;
      partial_data  = 16'sd500;
      do_start(8'd1);
      partial_valid = 1'b0;
      chk("t4_start_wins", 32'(err_drop), 0);
      for (int c = 0; c < DIM; c++) send(4'(c), 16'sd2);
      drain_expect("t4b", 2, 2, 2, 2);

      // 20 x 32767 into column 0 of a 20-bit accumulator.
      do_start(8'd1);
      for (int k = 0; k < 20; k++) send(4'd0, 16'sd32767);
      send(4'd3, 16'sd0);
`ifdef TPA_SATURATE_EN
      chk("t5_ovf", 32'(overflow), 1);
      drain_expect("t5", 524287, 0, 0, 0);
`else
      chk("t5_ovf", 32'(overflow), 0);
      drain_expect("t5", -393236, 0, 0, 0);
`endif

      // Reset during ACCUM, then a clean run.
      do_start(8'd1);
      send(4'd0, 16'sd50);
      send(4'd1, 16'sd60);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_valid", 32'(acc_out_valid), 0);
      chk("t6_done", 32'(done), 0);
      chk("t6_ovf", 32'(overflow), 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_idle", 32'(busy), 0);
      do_start(8'd1);
      for (int c = 0; c < DIM; c++) send(4'(c), 16'(c + 1));
      drain_expect("t6", 1, 2, 3, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
